// File: rtl/output64.sv
`default_nettype none
// ============================================================================
// Module      : output64
// Description : 64-bit word to UART transmitter. Accepts one word over a
//               valid/ready handshake and sends it as eight 8N1 frames,
//               most-significant byte first and each byte LSB first. Optional
//               idle gap after every stop bit (GAP_BITS). Defining the macro
//               OUTPUT64_HEADER_EN prepends one 0xFF sync frame to each word.
// Revision    : 1.0 - initial release
// ============================================================================
module output64 #(
    parameter int CLK_HZ   = 50000000,
    parameter int BIT_RATE = 9600,
    parameter int GAP_BITS = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [63:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        uart_txd,
    output logic        busy,
    output logic        done,
    output logic [2:0]  fsm_state,
    output logic [3:0]  byteCnt
);

    localparam int c_CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int c_GAP_CYCLES     = GAP_BITS * c_CYCLES_PER_BIT;
    localparam int c_TMR_MAX        = (c_GAP_CYCLES > c_CYCLES_PER_BIT) ?
                                      c_GAP_CYCLES : c_CYCLES_PER_BIT;
    localparam int c_TMR_W          = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;

    localparam logic [c_TMR_W-1:0] c_BIT_LAST = c_TMR_W'(c_CYCLES_PER_BIT - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LAST =
        c_TMR_W'((GAP_BITS > 0) ? (c_GAP_CYCLES - 1) : 0);
    localparam logic               c_GAP_EN   = 1'(GAP_BITS > 0);
    localparam logic [7:0]         c_SYNC_BYTE = 8'hFF;

`ifdef OUTPUT64_HEADER_EN
    localparam logic       c_HDR_EN = 1'b1;
    localparam logic [3:0] c_FRAMES = 4'd9;
`else
    localparam logic       c_HDR_EN = 1'b0;
    localparam logic [3:0] c_FRAMES = 4'd8;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t               r_state;
    logic [c_TMR_W-1:0]   r_timer;
    logic [2:0]           r_bit;
    logic [63:0]          r_shift;
    logic [3:0]           r_cnt;
    logic                 r_hdr;     // frame in flight is the sync header
    logic                 r_pre;     // first cycle after acceptance, line still idle
    logic                 r_txd;

    state_t               w_state_next;
    logic [c_TMR_W-1:0]   w_timer_next;
    logic [2:0]           w_bit_next;
    logic [63:0]          w_shift_next;
    logic [3:0]           w_cnt_next;
    logic                 w_hdr_next;
    logic                 w_pre_next;
    logic                 w_txd_next;
    logic                 w_bit_end;
    logic                 w_gap_end;
    logic                 w_last_byte;
    logic                 w_all_sent;
    logic [7:0]           w_tx_byte;

    // Next-state, datapath updates and the line value for the coming cycle.
    // The line is registered from next-state values so it changes exactly on
    // state boundaries; the one-cycle r_pre step delays the start bit to the
    // edge after acceptance.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        w_hdr_next   = r_hdr;
        w_pre_next   = 1'b0;
        w_txd_next   = 1'b1;
        w_tx_byte    = 8'h00;
        w_bit_end    = (r_timer == c_BIT_LAST);
        w_gap_end    = (r_timer == c_GAP_LAST);
        w_last_byte  = ((r_cnt + 4'd1) == c_FRAMES);
        w_all_sent   = (r_cnt == c_FRAMES);

        case (r_state)
            S_IDLE: begin
                w_timer_next = '0;
                w_bit_next   = '0;
                if (data_valid) begin
                    w_shift_next = data_in;
                    w_cnt_next   = 4'd0;
                    w_pre_next   = 1'b1;
                    w_hdr_next   = c_HDR_EN;
                    w_state_next = c_HDR_EN ? S_HEADER : S_START;
                end
            end
            S_HEADER, S_START: begin
                if (r_pre) begin
                    w_timer_next = '0;
                end else if (w_bit_end) begin
                    w_timer_next = '0;
                    w_bit_next   = 3'd0;
                    w_state_next = S_DATA;
                end else begin
                    w_timer_next = r_timer + c_TMR_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_timer_next = '0;
                    if (r_bit == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_timer_next = r_timer + c_TMR_W'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_timer_next = '0;
                    w_cnt_next   = r_cnt + 4'd1;
                    w_hdr_next   = 1'b0;
                    // The sync byte never occupied the shift register.
                    if (!r_hdr) begin
                        w_shift_next = {r_shift[55:0], 8'h00};
                    end
                    if (c_GAP_EN) begin
                        w_state_next = S_GAP;
                    end else if (w_last_byte) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_START;
                    end
                end else begin
                    w_timer_next = r_timer + c_TMR_W'(1);
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_timer_next = '0;
                    w_state_next = w_all_sent ? S_DONE : S_START;
                end else begin
                    w_timer_next = r_timer + c_TMR_W'(1);
                end
            end
            S_DONE: begin
                w_timer_next = '0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_timer_next = '0;
                w_bit_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase

        w_tx_byte = w_hdr_next ? c_SYNC_BYTE : w_shift_next[63:56];
        case (w_state_next)
            S_HEADER, S_START: w_txd_next = w_pre_next;
            S_DATA:            w_txd_next = w_tx_byte[w_bit_next];
            default:           w_txd_next = 1'b1;
        endcase
    end

    // State, timers, shift register and the registered TX line.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_bit   <= 3'd0;
            r_shift <= 64'd0;
            r_cnt   <= 4'd0;
            r_hdr   <= 1'b0;
            r_pre   <= 1'b0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_cnt   <= w_cnt_next;
            r_hdr   <= w_hdr_next;
            r_pre   <= w_pre_next;
            r_txd   <= w_txd_next;
        end
    end

    assign data_ready = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign fsm_state  = r_state;
    assign byteCnt    = r_cnt;
    assign uart_txd   = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_output64.sv
`default_nettype none
// ============================================================================
// Module      : tb_output64
// Description : Directed self-checking bench for output64. Instance A runs
//               with no gap, instance B with GAP_BITS=2; both at 10 clocks
//               per bit. Expectations follow OUTPUT64_HEADER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output64;

    localparam int c_CPB = 10;
`ifdef OUTPUT64_HEADER_EN
    localparam int c_HDR = 1;
`else
    localparam int c_HDR = 0;
`endif
    localparam int c_NFR    = 8 + c_HDR;
    localparam int c_FR_A   = 10 * c_CPB;
    localparam int c_FR_B   = 12 * c_CPB;
    localparam int c_REC_SZ = 1300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn_a, val_a, rdy_a, txd_a, busy_a, done_a;
    logic [63:0] din_a;
    logic [2:0]  st_a;
    logic [3:0]  cnt_a;
    logic        rstn_b, val_b, rdy_b, txd_b, busy_b, done_b;
    logic [63:0] din_b;
    logic [2:0]  st_b;
    logic [3:0]  cnt_b;

    output64 #(.CLK_HZ(1000000), .BIT_RATE(100000), .GAP_BITS(0)) u_dut_a (
        .clk(clk), .resetn(rstn_a), .data_in(din_a), .data_valid(val_a),
        .data_ready(rdy_a), .uart_txd(txd_a), .busy(busy_a), .done(done_a),
        .fsm_state(st_a), .byteCnt(cnt_a)
    );

    output64 #(.CLK_HZ(1000000), .BIT_RATE(100000), .GAP_BITS(2)) u_dut_b (
        .clk(clk), .resetn(rstn_b), .data_in(din_b), .data_valid(val_b),
        .data_ready(rdy_b), .uart_txd(txd_b), .busy(busy_b), .done(done_b),
        .fsm_state(st_b), .byteCnt(cnt_b)
    );

    int checks = 0;
    int errors = 0;

    logic       rec_txd  [0:c_REC_SZ-1];
    logic       rec_done [0:c_REC_SZ-1];
    logic       rec_rdy  [0:c_REC_SZ-1];
    logic       rec_busy [0:c_REC_SZ-1];
    logic [3:0] rec_cnt  [0:c_REC_SZ-1];

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int which, input int k);
        if (which == 0) begin
            rec_txd[k] = txd_a; rec_done[k] = done_a; rec_rdy[k] = rdy_a;
            rec_busy[k] = busy_a; rec_cnt[k] = cnt_a;
        end else begin
            rec_txd[k] = txd_b; rec_done[k] = done_b; rec_rdy[k] = rdy_b;
            rec_busy[k] = busy_b; rec_cnt[k] = cnt_b;
        end
    endtask

    task automatic drive(input int which, input logic v, input logic [63:0] d);
        if (which == 0) begin val_a = v; din_a = d; end
        else            begin val_b = v; din_b = d; end
    endtask

    // Offers a word, waits for the acceptance edge T, then records ncyc cycles.
    // rec[k] holds the outputs sampled just after edge T+k.
    task automatic send_record(input int which, input logic [63:0] word,
                               input int ncyc, input bit pulse);
        int guard = 0;
        drive(which, 1'b1, word);
        while (((which == 0) ? rdy_a : rdy_b) !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check_val("accept_timeout", 64'(guard), 64'd0);
        @(posedge clk); #1;
        drive(which, 1'b0, ~word);
        sample(which, 0);
        for (int k = 1; k <= ncyc; k++) begin
            if (pulse && (k == 40 || k == 400)) drive(which, 1'b1, 64'h5555_0000_5555_0000);
            else                                drive(which, 1'b0, ~word);
            @(posedge clk); #1;
            sample(which, k);
        end
        drive(which, 1'b0, 64'd0);
    endtask

    // 8N1 decoder sampling mid-bit; shifts bytes in from the LSB end.
    task automatic decode(input int frame, output logic [63:0] word,
                          output logic [7:0] first, output int bad);
        logic [7:0] b;
        int base;
        word = 64'd0; first = 8'd0; bad = 0;
        for (int f = 0; f < c_NFR; f++) begin
            base = 1 + f * frame;
            if (rec_txd[base + 5] !== 1'b0) bad++;
            for (int i = 0; i < 8; i++) b[i] = rec_txd[base + 15 + 10 * i];
            if (rec_txd[base + 95] !== 1'b1) bad++;
            if (f == 0) first = b;
            if (f >= c_HDR) word = {word[55:0], b};
        end
    endtask

    task automatic count_done(input int ncyc, output int first_k, output int pulses);
        first_k = -1; pulses = 0;
        for (int k = 0; k <= ncyc; k++) begin
            if (rec_done[k] === 1'b1) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [63:0] w;
        logic [7:0]  fb;
        int bad, dk, np, n, kr, kf, base;

        rstn_a = 1'b0; rstn_b = 1'b0;
        drive(0, 1'b0, 64'd0); drive(1, 1'b0, 64'd0);
        repeat (5) @(posedge clk);
        #1;
        rstn_a = 1'b1; rstn_b = 1'b1;
        check_val("rst_txd",   64'(txd_a), 64'd1);
        check_val("rst_ready", 64'(rdy_a), 64'd1);
        check_val("rst_cnt",   64'(cnt_a), 64'd0);
        check_val("rst_done",  64'(done_a), 64'd0);
        check_val("rst_state", 64'(st_a),  64'd0);
        check_val("rst_busy",  64'(busy_a), 64'd0);
        check_val("rst_txd_b", 64'(txd_b), 64'd1);
        repeat (2) @(posedge clk);
        #1;

        // Basic word, no gap
        n = c_NFR * c_FR_A + 4;
        send_record(0, 64'h0123_4567_89AB_CDEF, n, 1'b0);
        check_val("idle_at_T",   64'(rec_txd[0]), 64'd1);
        check_val("busy_at_T",   64'(rec_busy[0]), 64'd1);
        check_val("ready_at_T",  64'(rec_rdy[0]), 64'd0);
        check_val("start_T1",    64'(rec_txd[1]), 64'd0);
        decode(c_FR_A, w, fb, bad);
        check_val("word_a",      w, 64'h0123_4567_89AB_CDEF);
        check_val("first_a",     64'(fb), (c_HDR != 0) ? 64'hFF : 64'h01);
        check_val("framing_a",   64'(bad), 64'd0);
        count_done(n, dk, np);
        check_val("done_time_a", 64'(dk), 64'(c_NFR * c_FR_A + 1));
        check_val("done_once_a", 64'(np), 64'd1);
        check_val("cnt_end_a",   64'(rec_cnt[c_NFR * c_FR_A + 1]), 64'(c_NFR));
        check_val("rdy_done_a",  64'(rec_rdy[c_NFR * c_FR_A + 1]), 64'd0);
        check_val("rdy_after_a", 64'(rec_rdy[c_NFR * c_FR_A + 2]), 64'd1);
        check_val("cnt_mid_a",   64'(rec_cnt[150]), 64'd1);

        // Bit timing with alternating pattern and ignored valid pulses
        send_record(0, 64'hAAAA_AAAA_AAAA_AAAA, n, 1'b1);
        bad = 0;
        for (int k = 1; k <= n; k++)
            if (rec_txd[k] !== rec_txd[k - 1] && ((k - 1) % c_CPB) != 0) bad++;
        check_val("edge_align",  64'(bad), 64'd0);
        decode(c_FR_A, w, fb, bad);
        check_val("word_aa",     w, 64'hAAAA_AAAA_AAAA_AAAA);
        count_done(n, dk, np);
        check_val("done_time_aa", 64'(dk), 64'(c_NFR * c_FR_A + 1));
        check_val("done_once_aa", 64'(np), 64'd1);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (txd_a !== 1'b1 || st_a !== 3'd0) bad++;
        end
        check_val("no_second_word", 64'(bad), 64'd0);

        // Gap between frames on instance B
        n = c_NFR * c_FR_B + 4;
        send_record(1, 64'h0123_4567_89AB_CDEF, n, 1'b0);
        decode(c_FR_B, w, fb, bad);
        check_val("word_b",      w, 64'h0123_4567_89AB_CDEF);
        check_val("framing_b",   64'(bad), 64'd0);
        count_done(n, dk, np);
        check_val("done_time_b", 64'(dk), 64'(c_NFR * c_FR_B + 1));
        check_val("cnt_end_b",   64'(rec_cnt[c_NFR * c_FR_B + 1]), 64'(c_NFR));
        base = 1 + c_HDR * c_FR_B;
        check_val("last_bit_low_b", 64'(rec_txd[base + 89]), 64'd0);
        kr = -1; kf = -1;
        for (int k = base + 89; k < base + 2 * c_FR_B; k++) begin
            if (kr < 0 && rec_txd[k] === 1'b1) kr = k;
            if (kr >= 0 && kf < 0 && rec_txd[k] === 1'b0) kf = k;
        end
        check_val("stop_rise_b", 64'(kr), 64'(base + 90));
        check_val("gap_len_b",   64'(kf - kr), 64'd30);

        // Reset during byte 3's data bits
        kr = 1 + (3 + c_HDR) * c_FR_A + 45;
        send_record(0, 64'h1357_9BDF_2468_ACE0, kr, 1'b0);
        check_val("cnt_before_rst", 64'(rec_cnt[kr]), 64'(3 + c_HDR));
        rstn_a = 1'b0;
        @(posedge clk); #1;
        rstn_a = 1'b1;
        check_val("mid_rst_txd",   64'(txd_a), 64'd1);
        check_val("mid_rst_ready", 64'(rdy_a), 64'd1);
        check_val("mid_rst_cnt",   64'(cnt_a), 64'd0);
        check_val("mid_rst_state", 64'(st_a),  64'd0);
        bad = 0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            if (done_a !== 1'b0 || txd_a !== 1'b1) bad++;
        end
        check_val("no_done_after_rst", 64'(bad), 64'd0);
        n = c_NFR * c_FR_A + 4;
        send_record(0, 64'hFEDC_BA98_7654_3210, n, 1'b0);
        decode(c_FR_A, w, fb, bad);
        check_val("word_post_rst",  w, 64'hFEDC_BA98_7654_3210);
        check_val("first_post_rst", 64'(fb), (c_HDR != 0) ? 64'hFF : 64'hFE);
        count_done(n, dk, np);
        check_val("done_post_rst",  64'(dk), 64'(c_NFR * c_FR_A + 1));

        // All-zero word (header build shows the 0xFF sync frame first)
        send_record(0, 64'd0, n, 1'b0);
        decode(c_FR_A, w, fb, bad);
        check_val("word_zero",   w, 64'd0);
        check_val("first_zero",  64'(fb), (c_HDR != 0) ? 64'hFF : 64'h00);
        check_val("framing_zero", 64'(bad), 64'd0);
        count_done(n, dk, np);
        check_val("done_zero",   64'(dk), 64'(c_NFR * c_FR_A + 1));
        check_val("cnt_zero",    64'(rec_cnt[c_NFR * c_FR_A + 1]), 64'(c_NFR));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
